// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu bus master: register map, status bits,
// FSM and bus-phase encodings, and the single-access command bundle.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;

    localparam int STAT_READY = 1;
    localparam int STAT_VALID = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_START,
        ST_SETTLE,
        ST_RD_STAT,
        ST_CHECK,
        ST_RD_W,
        ST_RD_L,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    function automatic logic [31:0] zext_operand(input logic [23:0] op);
        return {8'h00, op};
    endfunction

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// One peripheral access: SETUP, STROBE_CYCLES of srd/swr, HOLD. A new access
// may be launched in the HOLD cycle so consecutive accesses run back-to-back.
module gpioemu_bus_cycle
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  bus_cmd_t    cmd,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd
);

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_CYCLES - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_cmd_t         cmd_q, cmd_d;
    logic             srd_q, srd_d;
    logic             swr_q, swr_d;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        phase_d = phase_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        srd_d   = 1'b0;
        swr_d   = 1'b0;
        unique case (phase_q)
            PH_SETUP: begin
                phase_d = PH_STROBE;
                cnt_d   = '0;
                srd_d   = ~cmd_q.we;
                swr_d   = cmd_q.we;
            end
            PH_STROBE: begin
                if (cnt_q == LAST) begin
                    phase_d = PH_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    srd_d = srd_q;
                    swr_d = swr_q;
                end
            end
            PH_HOLD: begin
                phase_d = PH_IDLE;
                cmd_d   = '0;
            end
            default: ;
        endcase
        if (start && (phase_q == PH_IDLE || phase_q == PH_HOLD)) begin
            phase_d = PH_SETUP;
            cmd_d   = cmd;
        end
    end

    // NOTE: synchronous reset lives inside the clocked block and uses <= like every other state update.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
        end
    end

    assign done     = (phase_q == PH_HOLD);
    assign rdata    = sdata_rd;
    assign saddress = cmd_q.addr;
    assign sdata_wr = cmd_q.wdata;
    assign srd      = srd_q;
    assign swr      = swr_q;

endmodule

// File: rtl/gpioemu_bus_master.sv
// Drives the gpioemu multiplier through write A1/A2, start, status polling and
// result reads, presenting operands and results on valid/ready ports.
module gpioemu_bus_master
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int POLL_LIMIT    = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_a1,
    input  logic [23:0] req_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_ovf,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd,
    output logic        busy
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] POLL_MAX    = 8'(POLL_LIMIT);

    state_e      state_q, state_d;
    logic [23:0] a1_q, a1_d;
    logic [23:0] a2_q, a2_d;
    logic [7:0]  settle_q, settle_d;
    logic [7:0]  poll_q, poll_d;
    logic [1:0]  stat_q, stat_d;
    logic        ovf_q, ovf_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_w_q, rsp_w_d;
    logic [23:0] rsp_l_q, rsp_l_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic        bus_start;
    bus_cmd_t    bus_cmd;
    logic        bus_done;
    logic [31:0] bus_rdata;

    gpioemu_bus_cycle #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_bus_cycle (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (bus_start),
        .cmd      (bus_cmd),
        .done     (bus_done),
        .rdata    (bus_rdata),
        .saddress (saddress),
        .srd      (srd),
        .swr      (swr),
        .sdata_wr (sdata_wr),
        .sdata_rd (sdata_rd)
    );

    // Each access is launched on the edge that enters its state, so there is no gap between accesses.
    always_comb begin
        state_d       = state_q;
        a1_d          = a1_q;
        a2_d          = a2_q;
        settle_d      = settle_q;
        poll_d        = poll_q;
        stat_d        = stat_q;
        ovf_d         = ovf_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_w_d       = rsp_w_q;
        rsp_l_d       = rsp_l_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_timeout_d = rsp_timeout_q;
        bus_start     = 1'b0;
        bus_cmd       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a1_d      = req_a1;
                    a2_d      = req_a2;
                    state_d   = ST_WR_A1;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b1, addr: ADDR_A1, wdata: zext_operand(req_a1)};
                end
            end
            ST_WR_A1: begin
                if (bus_done) begin
                    state_d   = ST_WR_A2;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b1, addr: ADDR_A2, wdata: zext_operand(a2_q)};
                end
            end
            ST_WR_A2: begin
                if (bus_done) begin
                    state_d   = ST_WR_START;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b1, addr: ADDR_CTRL, wdata: 32'h0};
                end
            end
            ST_WR_START: begin
                if (bus_done) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d   = ST_RD_STAT;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b0, addr: ADDR_CTRL, wdata: 32'h0};
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_RD_STAT: begin
                if (bus_done) begin
                    poll_d  = poll_q + 8'd1;
                    stat_d  = bus_rdata[1:0];
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (stat_q[STAT_READY]) begin
                    ovf_d     = ~stat_q[STAT_VALID];
                    state_d   = ST_RD_W;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b0, addr: ADDR_W, wdata: 32'h0};
                end else if (poll_q == POLL_MAX) begin
                    rsp_w_d       = '0;
                    rsp_l_d       = '0;
                    rsp_ovf_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    state_d   = ST_RD_STAT;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b0, addr: ADDR_CTRL, wdata: 32'h0};
                end
            end
            ST_RD_W: begin
                if (bus_done) begin
                    rsp_w_d   = bus_rdata;
                    state_d   = ST_RD_L;
                    bus_start = 1'b1;
                    bus_cmd   = '{we: 1'b0, addr: ADDR_L, wdata: 32'h0};
                end
            end
            ST_RD_L: begin
                if (bus_done) begin
                    rsp_l_d       = bus_rdata[23:0];
                    rsp_ovf_d     = ovf_q;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    poll_d      = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            a1_q          <= '0;
            a2_q          <= '0;
            settle_q      <= '0;
            poll_q        <= '0;
            stat_q        <= '0;
            ovf_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_w_q       <= '0;
            rsp_l_q       <= '0;
            rsp_ovf_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a1_q          <= a1_d;
            a2_q          <= a2_d;
            settle_q      <= settle_d;
            poll_q        <= poll_d;
            stat_q        <= stat_d;
            ovf_q         <= ovf_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_w_q       <= rsp_w_d;
            rsp_l_q       <= rsp_l_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = ~req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_w       = rsp_w_q;
    assign rsp_l       = rsp_l_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Directed bench for gpioemu_bus_master with a behavioural gpioemu peripheral
// and a bus monitor checking strobe width, stability and access order.
module tb_gpioemu_bus_master;
    import gpioemu_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_a1 = '0;
    logic [23:0] req_a2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_ovf;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    gpioemu_bus_master dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a1      (req_a1),
        .req_a2      (req_a2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_w       (rsp_w),
        .rsp_l       (rsp_l),
        .rsp_ovf     (rsp_ovf),
        .rsp_timeout (rsp_timeout),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_wr    (sdata_wr),
        .sdata_rd    (sdata_rd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Peripheral model state; status reports ready on poll number ready_after.
    logic [23:0] m_a1 = '0;
    logic [23:0] m_a2 = '0;
    int          status_polls = 0;
    int          ready_after = 1;
    bit          mode_stuck = 1'b0;
    logic [47:0] m_prod;
    logic        m_ready;

    always_comb begin
        m_prod   = {24'h0, m_a1} * {24'h0, m_a2};
        m_ready  = (status_polls >= ready_after);
        sdata_rd = 32'h0;
        case (saddress)
            ADDR_CTRL: if (!mode_stuck) sdata_rd = {30'h0, m_ready, (m_prod[47:32] == 16'h0)};
            ADDR_W:    sdata_rd = m_prod[31:0];
            ADDR_L:    sdata_rd = 32'($countones(m_prod[31:0]));
            default:   sdata_rd = 32'h0;
        endcase
    end

    // Bus monitor and peripheral register updates, sampled on the falling edge.
    int          mon_err = 0;
    int          run = 0;
    int          rd_ctrl = 0;
    int          rd_w = 0;
    int          rd_l = 0;
    logic        prev_strobe = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [15:0] acc_addr = '0;
    logic [31:0] acc_data = '0;
    logic        acc_we = 1'b0;
    logic [15:0] wr_log[$];

    always @(negedge clk) begin
        if (!n_reset) begin
            run         = 0;
            prev_strobe = 1'b0;
            prev_addr   = saddress;
            prev_data   = sdata_wr;
        end else begin
            if (srd && swr) mon_err++;
            if (swr) begin
                case (saddress)
                    ADDR_A1:   m_a1 = sdata_wr[23:0];
                    ADDR_A2:   m_a2 = sdata_wr[23:0];
                    ADDR_CTRL: status_polls = 0;
                    default: ;
                endcase
            end
            if ((srd || swr) && !prev_strobe) begin
                run      = 1;
                acc_addr = saddress;
                acc_data = sdata_wr;
                acc_we   = swr;
                if (prev_addr !== saddress || prev_data !== sdata_wr) mon_err++;
                if (swr) wr_log.push_back(saddress);
                if (srd) begin
                    case (saddress)
                        ADDR_CTRL: begin rd_ctrl++; status_polls++; end
                        ADDR_W:    rd_w++;
                        ADDR_L:    rd_l++;
                        default: ;
                    endcase
                end
            end else if (srd || swr) begin
                run++;
                if (saddress !== acc_addr || sdata_wr !== acc_data || swr !== acc_we) mon_err++;
            end else if (prev_strobe) begin
                if (run != 2 || saddress !== acc_addr || sdata_wr !== acc_data) mon_err++;
            end
            prev_strobe = srd || swr;
            prev_addr   = saddress;
            prev_data   = sdata_wr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_req(input logic [23:0] a1, input logic [23:0] a2);
        req_a1    = a1;
        req_a2    = a2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!rsp_valid && cyc < 3000);
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (srd !== 1'b0 || swr !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got srd=%b swr=%b want 0 0", srd, swr); end
        vectors++; if (saddress !== 16'h0) begin miscompares++; $display("FAIL reset_saddress: got %h want 0000", saddress); end
        vectors++; if (sdata_wr !== 32'h0) begin miscompares++; $display("FAIL reset_sdata_wr: got %h want 0", sdata_wr); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_w !== 32'h0 || rsp_l !== 24'h0) begin miscompares++; $display("FAIL reset_rsp_data: got w=%h l=%h want 0 0", rsp_w, rsp_l); end
        vectors++; if (rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_flags: got ovf=%b to=%b want 0 0", rsp_ovf, rsp_timeout); end
        n_reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc;
        int wb = wr_log.size();
        int eb = mon_err;
        int cb = rd_ctrl;
        send_req(24'd3, 24'd5);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || cyc != 29) begin miscompares++; $display("FAIL basic_latency: got valid=%b after %0d cycles want 1 after 29", rsp_valid, cyc); end
        vectors++; if (rsp_w !== 32'd15) begin miscompares++; $display("FAIL basic_w: got %h want %h", rsp_w, 32'd15); end
        vectors++; if (rsp_l !== 24'd4) begin miscompares++; $display("FAIL basic_l: got %0d want 4", rsp_l); end
        vectors++; if (rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL basic_flags: got ovf=%b to=%b want 0 0", rsp_ovf, rsp_timeout); end
        vectors++; if (wr_log.size() - wb != 3) begin miscompares++; $display("FAIL basic_write_count: got %0d want 3", wr_log.size() - wb); end
        vectors++; if (wr_log[wb] !== ADDR_A1 || wr_log[wb+1] !== ADDR_A2 || wr_log[wb+2] !== ADDR_CTRL) begin miscompares++; $display("FAIL basic_write_order: got %h %h %h want 037f 0388 03a0", wr_log[wb], wr_log[wb+1], wr_log[wb+2]); end
        vectors++; if (rd_ctrl - cb != 1) begin miscompares++; $display("FAIL basic_polls: got %0d want 1", rd_ctrl - cb); end
        vectors++; if (mon_err != eb) begin miscompares++; $display("FAIL basic_bus_protocol: got %0d violations want 0", mon_err - eb); end
        accept_rsp();
    endtask

    task automatic test_overflow();
        int cyc;
        int eb = mon_err;
        send_req(24'hFFFFFF, 24'hFFFFFF);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || cyc != 29) begin miscompares++; $display("FAIL ovf_latency: got valid=%b after %0d cycles want 1 after 29", rsp_valid, cyc); end
        vectors++; if (rsp_w !== 32'hFE000001) begin miscompares++; $display("FAIL ovf_w: got %h want fe000001", rsp_w); end
        vectors++; if (rsp_l !== 24'd8) begin miscompares++; $display("FAIL ovf_l: got %0d want 8", rsp_l); end
        vectors++; if (rsp_ovf !== 1'b1 || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL ovf_flags: got ovf=%b to=%b want 1 0", rsp_ovf, rsp_timeout); end
        vectors++; if (mon_err != eb) begin miscompares++; $display("FAIL ovf_bus_protocol: got %0d violations want 0", mon_err - eb); end
        accept_rsp();
    endtask

    task automatic test_extra_polls();
        int cyc;
        int cb = rd_ctrl;
        ready_after = 3;
        send_req(24'd7, 24'd9);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || cyc != 39) begin miscompares++; $display("FAIL polls_latency: got valid=%b after %0d cycles want 1 after 39", rsp_valid, cyc); end
        vectors++; if (rd_ctrl - cb != 3) begin miscompares++; $display("FAIL polls_count: got %0d want 3", rd_ctrl - cb); end
        vectors++; if (rsp_w !== 32'd63 || rsp_l !== 24'd6) begin miscompares++; $display("FAIL polls_result: got w=%0d l=%0d want 63 6", rsp_w, rsp_l); end
        accept_rsp();
        ready_after = 1;
    endtask

    task automatic test_backpressure();
        int cyc;
        send_req(24'd2, 24'd3);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || rsp_w !== 32'd6 || rsp_l !== 24'd2) begin miscompares++; $display("FAIL bp_result: got valid=%b w=%0d l=%0d want 1 6 2", rsp_valid, rsp_w, rsp_l); end
        req_a1    = 24'd10;
        req_a2    = 24'd10;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_w !== 32'd6 || rsp_l !== 24'd2 || rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL bp_hold_%0d: got valid=%b w=%0d l=%0d want 1 6 2", i, rsp_valid, rsp_w, rsp_l); end
            vectors++; if (req_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_ready_%0d: got req_ready=%b busy=%b want 0 1", i, req_ready, busy); end
            vectors++; if (srd !== 1'b0 || swr !== 1'b0 || saddress !== 16'h0) begin miscompares++; $display("FAIL bp_bus_idle_%0d: got srd=%b swr=%b addr=%h want 0 0 0000", i, srd, swr, saddress); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_handshake: got valid=%b req_ready=%b want 0 1", rsp_valid, req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_next: got req_ready=%b want 0", req_ready); end
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || cyc != 29 || rsp_w !== 32'd100 || rsp_l !== 24'd3) begin miscompares++; $display("FAIL bp_next_result: got valid=%b cyc=%0d w=%0d l=%0d want 1 29 100 3", rsp_valid, cyc, rsp_w, rsp_l); end
        accept_rsp();
    endtask

    task automatic test_timeout();
        int cyc;
        int cb = rd_ctrl;
        int wb = rd_w;
        int lb = rd_l;
        int eb = mon_err;
        mode_stuck = 1'b1;
        send_req(24'd5, 24'd5);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got valid=%b to=%b want 1 1", rsp_valid, rsp_timeout); end
        vectors++; if (rsp_w !== 32'h0 || rsp_l !== 24'h0) begin miscompares++; $display("FAIL to_result: got w=%h l=%h want 0 0", rsp_w, rsp_l); end
        vectors++; if (rd_ctrl - cb != 255) begin miscompares++; $display("FAIL to_polls: got %0d want 255", rd_ctrl - cb); end
        vectors++; if (rd_w != wb || rd_l != lb) begin miscompares++; $display("FAIL to_no_result_reads: got w_reads=%0d l_reads=%0d want 0 0", rd_w - wb, rd_l - lb); end
        vectors++; if (mon_err != eb) begin miscompares++; $display("FAIL to_bus_protocol: got %0d violations want 0", mon_err - eb); end
        accept_rsp();
        mode_stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int eb;
        bit found = 1'b0;
        send_req(24'd4, 24'd6);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (swr && saddress == ADDR_A2) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_reach_a2: got no WR_A2 strobe want one within 50 cycles"); end
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (swr !== 1'b0 || srd !== 1'b0 || saddress !== 16'h0) begin miscompares++; $display("FAIL rstmid_bus: got swr=%b srd=%b addr=%h want 0 0 0000", swr, srd, saddress); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        eb = mon_err;
        send_req(24'd4, 24'd6);
        wait_rsp(cyc);
        vectors++; if (rsp_valid !== 1'b1 || cyc != 29 || rsp_w !== 32'd24 || rsp_l !== 24'd2) begin miscompares++; $display("FAIL rstmid_recover: got valid=%b cyc=%0d w=%0d l=%0d want 1 29 24 2", rsp_valid, cyc, rsp_w, rsp_l); end
        vectors++; if (mon_err != eb) begin miscompares++; $display("FAIL rstmid_bus_protocol: got %0d violations want 0", mon_err - eb); end
        accept_rsp();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_extra_polls();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
